multi_lap_timer: RTL

MULTI_LAP_TIMER -- requirements
Module: multi_lap_timer

---
 rtl/multi_lap_timer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/multi_lap_timer.sv
// Multi-channel lap/countdown timer sharing one prescaler; each channel is an
// independent IDLE/RUN/EXPIRED machine addressed through ch_sel.
module multi_lap_timer #(
  parameter int WIDTH    = 12,
  parameter int CH       = 2,
  parameter int LAP_STEP = 30,
  parameter int PRESCALE = 100
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [$clog2(CH)-1:0] ch_sel,
  input  logic                  mode_down,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  lap,
  input  logic                  clear,
  output logic [CH*WIDTH-1:0]   count_o,
  output logic [CH-1:0]         running,
  output logic [CH-1:0]         time_up,
  output logic [WIDTH-1:0]      lap_val,
  output logic [$clog2(CH)-1:0] lap_ch,
  output logic                  lap_valid
);

  localparam int CW = $clog2(CH);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH:0]   STEP = (WIDTH+1)'(LAP_STEP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EXP  = 2'd2
  } state_e;

  state_e           state_q [CH];
  state_e           state_d [CH];
  logic [WIDTH-1:0] cnt_q   [CH];
  logic [WIDTH-1:0] cnt_d   [CH];
  logic [WIDTH:0]   lap_sum [CH];
  logic [CH-1:0]    mode_q, mode_d;
  logic [CH-1:0]    sel;
  logic [PW-1:0]    psc_q, psc_d;
  logic             tick;
  logic [WIDTH-1:0] lap_val_q, lap_val_d;
  logic [CW-1:0]    lap_ch_q, lap_ch_d;
  logic             lap_valid_q, lap_valid_d;

  assign tick  = (psc_q == PW'(PRESCALE - 1));
  assign psc_d = tick ? '0 : psc_q + 1'b1;

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      sel[i]     = (ch_sel == CW'(i));
      lap_sum[i] = {1'b0, cnt_q[i]} + STEP;
    end
  end

  // Command handling for the selected channel; the tick update is skipped
  // whenever stop/clear hits that channel, since those branches exit early.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    lap_val_d   = lap_val_q;
    lap_ch_d    = lap_ch_q;
    lap_valid_d = 1'b0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (sel[i] && clear) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else if (sel[i] && stop) begin
        if (state_q[i] == ST_RUN) state_d[i] = ST_IDLE;
      end else begin
        if (sel[i] && start) begin
          if (state_q[i] == ST_IDLE) begin
            mode_d[i] = mode_down;
            if (mode_down ? (cnt_q[i] == '0) : (cnt_q[i] == MAXV))
              state_d[i] = ST_EXP;
            else
              state_d[i] = ST_RUN;
          end
        end else if (sel[i] && lap) begin
          if (state_q[i] == ST_IDLE) begin
            cnt_d[i] = lap_sum[i][WIDTH] ? MAXV : lap_sum[i][WIDTH-1:0];
          end else if (state_q[i] == ST_RUN) begin
            lap_val_d   = cnt_q[i];
            lap_ch_d    = ch_sel;
            lap_valid_d = 1'b1;
          end
        end
        if (tick && state_q[i] == ST_RUN) begin
          if (mode_q[i]) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
            if (cnt_q[i] == WIDTH'(1)) state_d[i] = ST_EXP;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
            if (cnt_q[i] == MAXV - 1'b1) state_d[i] = ST_EXP;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      mode_q      <= '0;
      psc_q       <= '0;
      lap_val_q   <= '0;
      lap_ch_q    <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      mode_q      <= mode_d;
      psc_q       <= psc_d;
      lap_val_q   <= lap_val_d;
      lap_ch_q    <= lap_ch_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  always_comb begin
    count_o = '0;
    running = '0;
    time_up = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      count_o[i*WIDTH +: WIDTH] = cnt_q[i];
      running[i]                = (state_q[i] == ST_RUN);
      time_up[i]                = (state_q[i] == ST_EXP);
    end
  end

  assign lap_val   = lap_val_q;
  assign lap_ch    = lap_ch_q;
  assign lap_valid = lap_valid_q;

endmodule
